line_frame_scheduler: RTL and testbench



---
 rtl/line_pkg.sv | 33 +++
 rtl/line_frame_scheduler_rr_arbiter2.sv | 23 ++
 rtl/line_frame_scheduler.sv | 156 +++++++++++++++
 tb/tb_line_frame_scheduler.sv | 333 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/line_pkg.sv
// rtl/line_pkg.sv - shared types and constants for the line frame scheduler
// Purpose : coordinate width, visible raster size, FSM state encoding,
//           coordinate-pair struct and the optional endpoint clamp helper.
// Ports   : none (package).
// Macro   : LINE_CLAMP_EN (consumer side) selects whether clamp_coord is used.
package line_pkg;

  localparam int COORD_W  = 11;
  localparam int H_ACTIVE = 640;
  localparam int V_ACTIVE = 480;

  localparam logic [COORD_W-1:0] X_MAX = COORD_W'(H_ACTIVE - 1);
  localparam logic [COORD_W-1:0] Y_MAX = COORD_W'(V_ACTIVE - 1);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_HOLD = 1'b1
  } state_t;

  typedef struct packed {
    logic [COORD_W-1:0] x;
    logic [COORD_W-1:0] y;
  } coord_t;

  // Saturate an endpoint into the visible area; in-range values pass untouched.
  function automatic coord_t clamp_coord(input coord_t c);
    coord_t r;
    r.x = (c.x > X_MAX) ? X_MAX : c.x;
    r.y = (c.y > Y_MAX) ? Y_MAX : c.y;
    return r;
  endfunction

endpackage

// File: rtl/line_frame_scheduler_rr_arbiter2.sv
// rtl/line_frame_scheduler_rr_arbiter2.sv - two-input round-robin arbiter
// Purpose : combinational one-hot grant between two requesters.
// Ports   : i_valid[1:0] requester offers
//           i_ptr        requester that has priority this time
//           o_grant[1:0] one-hot grant (all zero when nobody is valid)
module rr_arbiter2 (
  input  logic [1:0] i_valid,
  input  logic       i_ptr,
  output logic [1:0] o_grant
);

  always_comb begin
    o_grant = 2'b00;
    if (i_ptr == 1'b0) begin
      if (i_valid[0])      o_grant = 2'b01;
      else if (i_valid[1]) o_grant = 2'b10;
    end else begin
      if (i_valid[1])      o_grant = 2'b10;
      else if (i_valid[0]) o_grant = 2'b01;
    end
  end

endmodule

// File: rtl/line_frame_scheduler.sv
// rtl/line_frame_scheduler.sv - frame-synchronous endpoint scheduler for line_logic
// Purpose : admits one endpoint sample from two producers (round-robin), holds
//           it pending and commits it to the active outputs at the next frame
//           start, so the drawn line never changes mid-frame. Blanks the line
//           after TIMEOUT_FRAMES frame starts without a commit (0 disables).
// Ports   : i_clk, i_rst (sync, active-high)
//           i_hcount/i_vcount        raster position
//           i_x0/i_y0/i_valid0/o_ready0  requester 0 (motion/sensor)
//           i_x1/i_y1/i_valid1/o_ready1  requester 1 (host/override)
//           o_x_val/o_y_val/o_vals_valid/o_src  active endpoint to line_logic
//           o_frame_commit           one-cycle pulse, aligned with new values
// Macro   : LINE_CLAMP_EN - saturate pending x/y to the visible area on load.
module line_frame_scheduler
  import line_pkg::*;
#(
  parameter int TIMEOUT_FRAMES = 60,
  parameter int TMO_W          = 8
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic [COORD_W-1:0] i_hcount,
  input  logic [COORD_W-1:0] i_vcount,
  input  logic [COORD_W-1:0] i_x0,
  input  logic [COORD_W-1:0] i_y0,
  input  logic               i_valid0,
  output logic               o_ready0,
  input  logic [COORD_W-1:0] i_x1,
  input  logic [COORD_W-1:0] i_y1,
  input  logic               i_valid1,
  output logic               o_ready1,
  output logic [COORD_W-1:0] o_x_val,
  output logic [COORD_W-1:0] o_y_val,
  output logic               o_vals_valid,
  output logic               o_src,
  output logic               o_frame_commit
);

  localparam logic [TMO_W-1:0] TMO_LIM = TMO_W'(TIMEOUT_FRAMES);
  localparam bit               TMO_EN  = (TIMEOUT_FRAMES != 0);

  state_t             r_state;
  state_t             w_state_nxt;
  logic               r_at_origin;
  logic               r_at_origin_q;
  logic               w_frame_start;
  logic               r_ptr;
  logic [1:0]         w_grant;
  logic               w_accept;
  logic               w_commit;
  coord_t             w_in_sel;
  coord_t             w_load;
  coord_t             r_pend;
  logic               r_pend_src;
  logic [TMO_W-1:0]   r_stale;
  logic [TMO_W-1:0]   w_stale_inc;
  logic               w_timeout_hit;
  logic [COORD_W-1:0] r_x_val;
  logic [COORD_W-1:0] r_y_val;
  logic               r_vals_valid;
  logic               r_src;
  logic               r_frame_commit;

  // Edge of the registered origin flag: a single pulse even when the raster
  // parks at (0,0) for several cycles.
  assign w_frame_start = r_at_origin & ~r_at_origin_q;

  rr_arbiter2 u_arb (
    .i_valid ({i_valid1, i_valid0}),
    .i_ptr   (r_ptr),
    .o_grant (w_grant)
  );

  always_comb begin
    w_in_sel = w_grant[1] ? coord_t'{x: i_x1, y: i_y1} : coord_t'{x: i_x0, y: i_y0};
  end

`ifdef LINE_CLAMP_EN
  assign w_load = clamp_coord(w_in_sel);
`else
  assign w_load = w_in_sel;
`endif

  assign w_stale_inc   = (&r_stale) ? r_stale : r_stale + 1'b1;
  assign w_timeout_hit = TMO_EN && (w_stale_inc >= TMO_LIM);

  always_comb begin
    w_state_nxt = r_state;
    o_ready0    = 1'b0;
    o_ready1    = 1'b0;
    w_accept    = 1'b0;
    w_commit    = 1'b0;
    case (r_state)
      S_IDLE: begin
        // Ready follows the grant, so a handshake is simply "any grant".
        o_ready0 = w_grant[0];
        o_ready1 = w_grant[1];
        if (|w_grant) begin
          w_accept    = 1'b1;
          w_state_nxt = S_HOLD;
        end
      end
      S_HOLD: begin
        if (w_frame_start) begin
          w_commit    = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state        <= S_IDLE;
      r_at_origin    <= 1'b0;
      r_at_origin_q  <= 1'b0;
      r_ptr          <= 1'b0;
      r_pend         <= '0;
      r_pend_src     <= 1'b0;
      r_stale        <= '0;
      r_x_val        <= '0;
      r_y_val        <= '0;
      r_vals_valid   <= 1'b0;
      r_src          <= 1'b0;
      r_frame_commit <= 1'b0;
    end else begin
      r_state        <= w_state_nxt;
      r_at_origin    <= (i_hcount == '0) && (i_vcount == '0);
      r_at_origin_q  <= r_at_origin;
      r_frame_commit <= w_commit;
      if (w_accept) begin
        r_pend     <= w_load;
        r_pend_src <= w_grant[1];
        r_ptr      <= ~w_grant[1];
      end
      if (w_commit) begin
        r_x_val      <= r_pend.x;
        r_y_val      <= r_pend.y;
        r_src        <= r_pend_src;
        r_vals_valid <= 1'b1;
        r_stale      <= '0;
      end else if (w_frame_start) begin
        // Frame went by without a new endpoint: age the data, keep x/y.
        r_stale <= w_stale_inc;
        if (w_timeout_hit) r_vals_valid <= 1'b0;
      end
    end
  end

  assign o_x_val        = r_x_val;
  assign o_y_val        = r_y_val;
  assign o_vals_valid   = r_vals_valid;
  assign o_src          = r_src;
  assign o_frame_commit = r_frame_commit;

endmodule

// File: tb/tb_line_frame_scheduler.sv
// tb/tb_line_frame_scheduler.sv - scoreboard bench for line_frame_scheduler
module tb_line_frame_scheduler;

  localparam int CW    = 11;
  localparam int TMO   = 3;
  localparam int H_TOT = 12;
  localparam int V_TOT = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic [CW-1:0] hcount, vcount, x0, y0, x1, y1;
  logic          valid0, valid1;
  logic          ready0, ready1;
  logic [CW-1:0] x_val, y_val;
  logic          vals_valid, src, frame_commit;

  always #5 clk = ~clk;

  line_frame_scheduler #(.TIMEOUT_FRAMES(TMO), .TMO_W(8)) dut (
    .i_clk(clk), .i_rst(rst), .i_hcount(hcount), .i_vcount(vcount),
    .i_x0(x0), .i_y0(y0), .i_valid0(valid0), .o_ready0(ready0),
    .i_x1(x1), .i_y1(y1), .i_valid1(valid1), .o_ready1(ready1),
    .o_x_val(x_val), .o_y_val(y_val), .o_vals_valid(vals_valid),
    .o_src(src), .o_frame_commit(frame_commit)
  );

  typedef struct { int x; int y; int src; } ev_t;

  int  n_checks = 0;
  int  n_fail   = 0;
  int  n_commit = 0;
  ev_t commit_q[$];
  ev_t drop_q[$];
  int  grant_q[$];
  int  seen_src[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic int cx(input int v);
`ifdef LINE_CLAMP_EN
    return (v > 639) ? 639 : v;
`else
    return v;
`endif
  endfunction

  function automatic int cy(input int v);
`ifdef LINE_CLAMP_EN
    return (v > 479) ? 479 : v;
`else
    return v;
`endif
  endfunction

  // Reference model: one pending slot, a priority flag that flips to the
  // loser after each grant, and a per-frame age count since the last commit.
  initial begin
    bit  org1 = 0, org2 = 0, busy = 0, pri = 0, mvalid = 0;
    int  stale = 0, mx = 0, my = 0, g;
    bit  fs, org;
    ev_t pend;
    forever begin
      @(negedge clk);
      org = (hcount == 0) && (vcount == 0);
      if (rst) begin
        org1 = 0; org2 = 0; busy = 0; pri = 0; mvalid = 0;
        stale = 0; mx = 0; my = 0;
      end else begin
        fs = org1 && !org2;
        if (busy) begin
          if (fs) begin
            commit_q.push_back(pend);
            mx = pend.x; my = pend.y; mvalid = 1; stale = 0; busy = 0;
          end
        end else begin
          g = -1;
          if (pri == 0) g = valid0 ? 0 : (valid1 ? 1 : -1);
          else          g = valid1 ? 1 : (valid0 ? 0 : -1);
          if (g == 0) pend = '{cx(int'(x0)), cy(int'(y0)), 0};
          if (g == 1) pend = '{cx(int'(x1)), cy(int'(y1)), 1};
          if (g >= 0) begin
            busy = 1;
            pri  = (g == 0);
            grant_q.push_back(g);
          end
          if (fs) begin
            if (stale < 255) stale++;
            if (stale >= TMO && mvalid) begin
              mvalid = 0;
              drop_q.push_back('{mx, my, 0});
            end
          end
        end
        org2 = org1;
        org1 = org;
      end
    end
  end

  // Monitor: pops expectations whenever the DUT shows a handshake, a commit
  // pulse, or a falling o_vals_valid.
  initial begin
    bit  prev_valid = 0, rst_last = 1;
    int  hs;
    ev_t e;
    forever begin
      @(negedge clk);
      #1;
      if (!rst) begin
        if (ready0 && ready1) check("ready_onehot", 1, 0);
        hs = (valid0 && ready0) ? 0 : ((valid1 && ready1) ? 1 : -1);
        if (hs >= 0) begin
          if (grant_q.size() == 0) check("grant_unexpected", hs, 32'hFFFF_FFFF);
          else check("grant_src", hs, grant_q.pop_front());
        end
        if (frame_commit) begin
          n_commit++;
          seen_src.push_back(int'(src));
          if (commit_q.size() == 0) check("commit_unexpected", 1, 0);
          else begin
            e = commit_q.pop_front();
            check("commit_x", x_val, e.x);
            check("commit_y", y_val, e.y);
            check("commit_src", src, e.src);
            check("commit_valid", vals_valid, 1);
          end
        end
        if (prev_valid && !vals_valid && !rst_last) begin
          if (drop_q.size() == 0) check("drop_unexpected", 1, 0);
          else begin
            e = drop_q.pop_front();
            check("drop_x_held", x_val, e.x);
            check("drop_y_held", y_val, e.y);
          end
        end
      end
      prev_valid = vals_valid;
      rst_last   = rst;
    end
  end

  // Stimulus
  int h_i = 5, v_i = 1, hold = 0;
  bit prev_org = 0, entered = 0;
  bit auto0 = 0, auto1 = 0, rand_mode = 0, rand_hold = 0;

  task automatic step();
    bit hs0, hs1;
    @(negedge clk);
    #2;
    hs0 = valid0 && ready0;
    hs1 = valid1 && ready1;
    @(posedge clk);
    #2;
    if (hs0 && !auto0) valid0 = 1'b0;
    if (hs1 && !auto1) valid1 = 1'b0;
    if (hold > 0) hold--;
    else begin
      h_i++;
      if (h_i == H_TOT) begin
        h_i = 0;
        v_i = (v_i == V_TOT - 1) ? 0 : v_i + 1;
      end
    end
    entered  = (h_i == 0 && v_i == 0) && !prev_org;
    prev_org = (h_i == 0 && v_i == 0);
    if (entered && rand_hold && $urandom_range(0, 2) == 0) hold = $urandom_range(0, 4);
    hcount = CW'(h_i);
    vcount = CW'(v_i);
    if (rand_mode) begin
      if (!valid0 && $urandom_range(0, 3) == 0) begin
        valid0 = 1'b1; x0 = CW'($urandom_range(0, 2047)); y0 = CW'($urandom_range(0, 2047));
      end
      if (!valid1 && $urandom_range(0, 3) == 0) begin
        valid1 = 1'b1; x1 = CW'($urandom_range(0, 2047)); y1 = CW'($urandom_range(0, 2047));
      end
    end
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic wait_origin();
    int n = 0;
    do begin
      step();
      n++;
    end while (!entered && n < 300);
    if (!entered) check("origin_timeout", 0, 1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0, ex, ey;
    rst = 1'b1; valid0 = 1'b0; valid1 = 1'b0;
    x0 = '0; y0 = '0; x1 = '0; y1 = '0;
    hcount = CW'(h_i); vcount = CW'(v_i);
    steps(3);
    check("rst_x", x_val, 0);
    check("rst_y", y_val, 0);
    check("rst_valid", vals_valid, 0);
    check("rst_src", src, 0);
    check("rst_commit", frame_commit, 0);
    rst = 1'b0;
    steps(2);

    // Single mid-frame request, committed at the next frame start.
    valid0 = 1'b1; x0 = CW'(100); y0 = CW'(50);
    steps(2);
    check("t1_ready_drop", ready0, 0);
    check("t1_hold_valid", vals_valid, 0);
    check("t1_hold_x", x_val, 0);
    wait_origin();
    steps(3);
    check("t1_x", x_val, 100);
    check("t1_y", y_val, 50);
    check("t1_valid", vals_valid, 1);
    check("t1_src", src, 0);
    check("t1_commits", n_commit, 1);

    // Both producers offering continuously: commits alternate source.
    seen_src.delete();
    auto0 = 1; auto1 = 1;
    valid0 = 1'b1; x0 = CW'(10); y0 = CW'(10);
    valid1 = 1'b1; x1 = CW'(20); y1 = CW'(20);
    for (int f = 0; f < 4; f++) wait_origin();
    steps(3);
    auto0 = 0; auto1 = 0; valid0 = 1'b0; valid1 = 1'b0;
    check("t2_commit_count", seen_src.size(), 4);
    for (int i = 1; i < seen_src.size(); i++)
      check("t2_src_alternates", seen_src[i] != seen_src[i-1], 1);
    wait_origin();
    wait_origin();

    // Accept on the frame_start cycle itself: commit waits a whole frame.
    wait_origin();
    step();
    valid0 = 1'b1; x0 = CW'(77); y0 = CW'(33);
    c0 = n_commit;
    steps(5);
    check("t3_no_commit_same_frame", n_commit, c0);
    wait_origin();
    steps(3);
    check("t3_commit_next_frame", n_commit, c0 + 1);
    check("t3_x", x_val, 77);

    // Raster parked at the origin: one frame start, one commit.
    steps(10);
    valid1 = 1'b1; x1 = CW'(250); y1 = CW'(150);
    wait_origin();
    hold = 4;
    c0 = n_commit;
    steps(20);
    check("t4_single_commit", n_commit, c0 + 1);
    check("t4_x", x_val, 250);

    // Stale timeout after three idle frame starts; x/y held; recovery.
    wait_origin();
    wait_origin();
    steps(3);
    check("t5_valid_before_tmo", vals_valid, 1);
    wait_origin();
    steps(3);
    check("t5_valid_dropped", vals_valid, 0);
    check("t5_x_held", x_val, 250);
    check("t5_y_held", y_val, 150);
    valid1 = 1'b1; x1 = CW'(300); y1 = CW'(200);
    wait_origin();
    steps(3);
    check("t5_valid_restored", vals_valid, 1);
    check("t5_new_x", x_val, 300);

    // Randomized traffic with occasional raster holds at the origin.
    rand_mode = 1; rand_hold = 1;
    for (int f = 0; f < 12; f++) wait_origin();
    rand_mode = 0; rand_hold = 0;
    valid0 = 1'b0; valid1 = 1'b0;
    wait_origin();
    wait_origin();
    steps(3);

    // Out-of-range endpoint (clamped only when the clamp is built in).
`ifdef LINE_CLAMP_EN
    ex = 639; ey = 479;
`else
    ex = 900; ey = 700;
`endif
    valid1 = 1'b1; x1 = CW'(900); y1 = CW'(700);
    wait_origin();
    steps(3);
    check("t6_clamp_x", x_val, ex);
    check("t6_clamp_y", y_val, ey);

    // Reset while a sample is pending: discarded, no commit.
    steps(8);
    valid0 = 1'b1; x0 = CW'(123); y0 = CW'(45);
    steps(3);
    rst = 1'b1;
    steps(2);
    rst = 1'b0;
    step();
    check("t6_rst_x", x_val, 0);
    check("t6_rst_y", y_val, 0);
    check("t6_rst_valid", vals_valid, 0);
    check("t6_rst_src", src, 0);
    c0 = n_commit;
    wait_origin();
    wait_origin();
    steps(3);
    check("t6_rst_no_commit", n_commit, c0);
    check("t6_rst_still_invalid", vals_valid, 0);

    check("end_grant_q_empty", grant_q.size(), 0);
    check("end_commit_q_empty", commit_q.size(), 0);
    check("end_drop_q_empty", drop_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
